// File: rtl/tpu_cmd_pkg.sv
// -----------------------------------------------------------------------------
// tpu_cmd_pkg
// Shared definitions for the TPU command-queue path: the opcode set, the
// scheduler error codes, the 128-bit descriptor layout and the bit positions
// of every descriptor field. The CMDQ register block uses the same field
// positions when it packs descriptors, so there is one place to change the
// layout.
// -----------------------------------------------------------------------------
package tpu_cmd_pkg;

  localparam int DESC_W       = 128;
  localparam int WGT_BASE_LSB = 0;
  localparam int WGT_BASE_W   = 16;
  localparam int M_TILE_LSB   = 16;
  localparam int K_TILE_LSB   = 24;
  localparam int TILE_W       = 8;
  localparam int ACT_BASE_LSB = 32;
  localparam int OUT_BASE_LSB = 64;
  localparam int BASE_W       = 32;
  localparam int OPCODE_LSB   = 96;
  localparam int OPCODE_W     = 8;
  localparam int IRQ_EN_BIT   = 118;

  typedef enum logic [7:0] {
    OP_GEMM      = 8'h00,
    OP_LOAD_GEMM = 8'h01,
    OP_LOAD      = 8'h02,
    OP_NOP       = 8'h03
  } cmd_opcode_e;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_ILLEGAL_OP = 3'd1,
    ERR_DMA        = 3'd2,
    ERR_CMP        = 3'd3,
    ERR_TIMEOUT    = 3'd4
  } sched_err_e;

  // Most-significant field first so the struct lines up with the bit
  // positions above when a 128-bit FIFO word is assigned to it.
  typedef struct packed {
    logic [8:0]  rsvd_hi;
    logic        irq_en;
    logic [13:0] rsvd_mid;
    logic [7:0]  opcode;
    logic [31:0] out_base;
    logic [31:0] act_base;
    logic [7:0]  k_tile;
    logic [7:0]  m_tile;
    logic [15:0] wgt_base;
  } cmd_desc_t;

  // DMA transfer size for a weight tile: one byte per k x m element.
  function automatic logic [15:0] tile_bytes(input logic [7:0] k, input logic [7:0] m);
    return {8'd0, k} * {8'd0, m};
  endfunction

endpackage

// File: rtl/tpu_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// tpu_cmd_scheduler
// Pops 128-bit descriptors from the TPU command FIFO while queue mode is on,
// drives the weight DMA and/or the systolic compute core for each one, waits
// for completion and retires it with an optional interrupt. Engine errors and
// illegal opcodes are latched until software pulses clr_err.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   en                  queue mode; low stops new fetches only
//   clr_err             pulse that clears the error latch and leaves ERROR
//   cmd_valid/ready     FIFO not-empty / one-cycle pop strobe
//   cmd_desc            FIFO head descriptor
//   dma_*               DMA start pulse, operands, done/err pulses
//   cmp_*               compute start pulse, operands, done/err pulses
//   busy, irq           activity flag, per-command retire interrupt
//   err, err_code       error latch and cause
//   retired_cnt         wrapping count of retired commands
//
// Build option: define CMDSCHED_TIMEOUT_EN to bound every engine wait to
// TIMEOUT_CYC cycles (error code 4 on expiry). Without it, waits are unbounded.
// -----------------------------------------------------------------------------
module tpu_cmd_scheduler
  import tpu_cmd_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int LEN_W       = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr_err,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [127:0]      cmd_desc,
  output logic              dma_start,
  output logic [ADDR_W-1:0] dma_src,
  output logic [ADDR_W-1:0] dma_dst,
  output logic [LEN_W-1:0]  dma_len,
  input  logic              dma_done,
  input  logic              dma_err,
  output logic              cmp_start,
  output logic [ADDR_W-1:0] cmp_wgt_base,
  output logic [ADDR_W-1:0] cmp_act_base,
  output logic [ADDR_W-1:0] cmp_out_base,
  output logic [7:0]        cmp_k,
  output logic [7:0]        cmp_m,
  input  logic              cmp_done,
  input  logic              cmp_err,
  output logic              busy,
  output logic              irq,
  output logic              err,
  output logic [2:0]        err_code,
  output logic [15:0]       retired_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DMA_GO, S_DMA_WAIT, S_CMP_GO, S_CMP_WAIT, S_RETIRE, S_ERROR
  } state_e;

  state_e     state_q, state_d;
  cmd_desc_t  head, desc_q;
  logic       err_set;
  sched_err_e err_code_d, err_code_q;
  logic       timeout_hit;

  assign head = cmd_desc;

  // Reserved descriptor bits are carried in the register but never used.
  logic unused_rsvd;
  assign unused_rsvd = ^{desc_q.rsvd_hi, desc_q.rsvd_mid, head.rsvd_hi, head.rsvd_mid};

`ifdef CMDSCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;
  logic [TO_W-1:0] wait_cnt;

  // Counts cycles spent in a WAIT state; the GO state that precedes every
  // WAIT restarts it, so each engine gets a fresh budget.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state_q == S_DMA_GO || state_q == S_CMP_GO) begin
      wait_cnt <= '0;
    end else if (state_q == S_DMA_WAIT || state_q == S_CMP_WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // True on the last permitted waiting cycle; done/err are checked first.
  assign timeout_hit = (wait_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. FETCH decodes straight from the FIFO head because the
  // descriptor register only captures it at the end of that cycle; later
  // decisions use the registered copy. Error beats done in the same cycle.
  always_comb begin
    state_d    = state_q;
    err_set    = 1'b0;
    err_code_d = ERR_NONE;
    case (state_q)
      S_IDLE:  if (en && cmd_valid) state_d = S_FETCH;
      S_FETCH: begin
        case (head.opcode)
          OP_GEMM:              state_d = S_CMP_GO;
          OP_LOAD_GEMM, OP_LOAD: state_d = S_DMA_GO;
          OP_NOP:               state_d = S_RETIRE;
          default: begin
            state_d    = S_ERROR;
            err_set    = 1'b1;
            err_code_d = ERR_ILLEGAL_OP;
          end
        endcase
      end
      S_DMA_GO: state_d = S_DMA_WAIT;
      S_DMA_WAIT: begin
        if (dma_err) begin
          state_d    = S_ERROR;
          err_set    = 1'b1;
          err_code_d = ERR_DMA;
        end else if (dma_done) begin
          state_d = (desc_q.opcode == OP_LOAD_GEMM) ? S_CMP_GO : S_RETIRE;
        end else if (timeout_hit) begin
          state_d    = S_ERROR;
          err_set    = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end
      end
      S_CMP_GO: state_d = S_CMP_WAIT;
      S_CMP_WAIT: begin
        if (cmp_err) begin
          state_d    = S_ERROR;
          err_set    = 1'b1;
          err_code_d = ERR_CMP;
        end else if (cmp_done) begin
          state_d = S_RETIRE;
        end else if (timeout_hit) begin
          state_d    = S_ERROR;
          err_set    = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end
      end
      S_RETIRE: state_d = S_IDLE;
      S_ERROR:  if (clr_err) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Descriptor register, retire counter and error latch. Operand outputs come
  // from desc_q so they stay stable until the next fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      desc_q      <= '0;
      retired_cnt <= '0;
      err         <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      if (state_q == S_FETCH) desc_q <= head;
      if (state_q == S_RETIRE) retired_cnt <= retired_cnt + 16'd1;
      if (err_set) begin
        err        <= 1'b1;
        err_code_q <= err_code_d;
      end else if (state_q == S_ERROR && clr_err) begin
        err        <= 1'b0;
        err_code_q <= ERR_NONE;
      end
    end
  end

  assign err_code     = err_code_q;
  assign cmd_ready    = (state_q == S_FETCH);
  assign dma_start    = (state_q == S_DMA_GO);
  assign cmp_start    = (state_q == S_CMP_GO);
  assign busy         = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign irq          = (state_q == S_RETIRE) && desc_q.irq_en;

  assign dma_src      = ADDR_W'(desc_q.act_base);
  assign dma_dst      = ADDR_W'(desc_q.wgt_base);
  assign dma_len      = LEN_W'(tile_bytes(desc_q.k_tile, desc_q.m_tile));
  assign cmp_wgt_base = ADDR_W'(desc_q.wgt_base);
  assign cmp_act_base = ADDR_W'(desc_q.act_base);
  assign cmp_out_base = ADDR_W'(desc_q.out_base);
  assign cmp_k        = desc_q.k_tile;
  assign cmp_m        = desc_q.m_tile;

endmodule
